// File: rtl/barrier_pkg.sv
// Shared constants and state encoding for the barrier-tree node sequencer.
package barrier_pkg;

    localparam logic [15:0] MSG_ARRIVE  = 16'h0001;
    localparam logic [15:0] MSG_RELEASE = 16'h0002;

    localparam logic [7:0] NODE_ROOT         = 8'd0;
    localparam logic [7:0] NODE_INTERMEDIATE = 8'd1;
    localparam logic [7:0] NODE_LEAF         = 8'd2;

    typedef enum logic [1:0] {
        GATHER       = 2'd0,
        SEND_UP      = 2'd1,
        WAIT_RELEASE = 2'd2,
        SEND_DOWN    = 2'd3
    } state_e;

endpackage

// File: rtl/barrier_ctrl_if.sv
// Transmit request bus between the barrier sequencer (master) and the packet generator (slave).
interface barrier_ctrl_if;

    logic        tx_req;
    logic [15:0] tx_msg;
    logic [15:0] tx_comm_id;
    logic        tx_to_parent;
    logic        tx_ack;

    modport master (
        output tx_req,
        output tx_msg,
        output tx_comm_id,
        output tx_to_parent,
        input  tx_ack
    );

    modport slave (
        input  tx_req,
        input  tx_msg,
        input  tx_comm_id,
        input  tx_to_parent,
        output tx_ack
    );

endinterface

// File: rtl/barrier_tx_req.sv
// Request/acknowledge register pair: loaded by the sequencer, request dropped on ack.
module barrier_tx_req
    import barrier_pkg::*;
(
    input  logic        clk,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [15:0] i_msg,
    input  logic        i_to_parent,
    input  logic [15:0] i_comm_id,
    output logic        o_acked,
    barrier_ctrl_if.master tx
);

    logic        r_req;
    logic [15:0] r_msg;
    logic [15:0] r_comm_id;
    logic        r_to_parent;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_req       <= 1'b0;
            r_msg       <= '0;
            r_comm_id   <= '0;
            r_to_parent <= 1'b0;
        end else if (i_load) begin
            r_req       <= 1'b1;
            r_msg       <= i_msg;
            r_comm_id   <= i_comm_id;
            r_to_parent <= i_to_parent;
        end else if (r_req && tx.tx_ack) begin
            r_req <= 1'b0;
        end
    end

    // An ack only counts while a request is actually outstanding.
    assign o_acked         = r_req & tx.tx_ack;
    assign tx.tx_req       = r_req;
    assign tx.tx_msg       = r_msg;
    assign tx.tx_comm_id   = r_comm_id;
    assign tx.tx_to_parent = r_to_parent;

endmodule

// File: rtl/barrier_ctrl.sv
// Barrier sequencer for one tree node: gather arrivals, report up, await release, broadcast down.
module barrier_ctrl
    import barrier_pkg::*;
#(
    parameter int          CNT_WIDTH   = 8,
    parameter logic [15:0] MSG_ARRIVE  = barrier_pkg::MSG_ARRIVE,
    parameter logic [15:0] MSG_RELEASE = barrier_pkg::MSG_RELEASE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_decode_done,
    input  logic                 i_barrier_pkt,
    input  logic [15:0]          i_message,
    input  logic [15:0]          i_comm_id,
    input  logic                 i_local_arrive,
    input  logic                 i_cfg_enable,
    input  logic [15:0]          i_cfg_comm_id,
    input  logic [7:0]           i_cfg_node_type,
    input  logic [CNT_WIDTH-1:0] i_cfg_num_children,
    barrier_ctrl_if.master       tx,
    output logic                 o_barrier_done,
    output logic [CNT_WIDTH-1:0] o_arrive_cnt,
    output logic                 o_err_pulse
);

    state_e               r_state, w_state_nx;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nx;
    logic                 r_seen, w_seen_nx;
    logic                 r_done, w_done_nx;
    logic                 r_err, w_err_nx;
    logic                 w_load;
    logic [15:0]          w_load_msg;
    logic                 w_load_up;
    logic                 w_acked;
    logic                 w_clr;
    logic                 w_relevant, w_foreign;
    logic                 w_arr, w_rel, w_other;
    logic                 w_no_children, w_is_root;

    // Disabling the block behaves exactly like reset but leaves cfg inputs alone.
    assign w_clr = reset || !i_cfg_enable;

    assign w_relevant    = i_decode_done && i_barrier_pkt && (i_comm_id == i_cfg_comm_id);
    assign w_foreign     = i_decode_done && i_barrier_pkt && (i_comm_id != i_cfg_comm_id);
    assign w_arr         = w_relevant && (i_message == MSG_ARRIVE);
    assign w_rel         = w_relevant && (i_message == MSG_RELEASE);
    assign w_other       = w_relevant && !w_arr && !w_rel;
    assign w_no_children = (i_cfg_num_children == '0);
    assign w_is_root     = (i_cfg_node_type == NODE_ROOT);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= GATHER;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_seen  <= w_seen_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_seen_nx  = r_seen;
        w_done_nx  = 1'b0;
        w_err_nx   = w_foreign || w_other;
        w_load     = 1'b0;
        w_load_msg = MSG_ARRIVE;
        w_load_up  = 1'b1;

        case (r_state)
            GATHER: begin
                if (w_arr) begin
                    if (r_cnt == i_cfg_num_children) w_err_nx = 1'b1;
                    else                             w_cnt_nx = r_cnt + 1'b1;
                end
                if (w_rel) w_err_nx = 1'b1;
                if (i_local_arrive) begin
                    if (r_seen) w_err_nx  = 1'b1;
                    else        w_seen_nx = 1'b1;
                end
                // Completion looks at the updated count/flag so same-cycle events finish the gather.
                if ((w_cnt_nx == i_cfg_num_children) && w_seen_nx) begin
                    if (w_is_root) begin
                        if (w_no_children) begin
                            w_done_nx = 1'b1;
                        end else begin
                            w_state_nx = SEND_DOWN;
                            w_load     = 1'b1;
                            w_load_msg = MSG_RELEASE;
                            w_load_up  = 1'b0;
                        end
                    end else begin
                        w_state_nx = SEND_UP;
                        w_load     = 1'b1;
                    end
                end
            end
            SEND_UP: begin
                if (w_arr || w_rel || i_local_arrive) w_err_nx = 1'b1;
                if (w_acked) w_state_nx = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (w_arr || i_local_arrive) w_err_nx = 1'b1;
                if (w_rel) begin
                    if (w_no_children) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = GATHER;
                    end else begin
                        w_state_nx = SEND_DOWN;
                        w_load     = 1'b1;
                        w_load_msg = MSG_RELEASE;
                        w_load_up  = 1'b0;
                    end
                end
            end
            SEND_DOWN: begin
                if (w_arr || w_rel || i_local_arrive) w_err_nx = 1'b1;
                if (w_no_children || w_acked) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = GATHER;
                end
            end
            default: w_state_nx = GATHER;
        endcase

        if (w_done_nx) begin
            w_cnt_nx  = '0;
            w_seen_nx = 1'b0;
        end
    end

    barrier_tx_req u_tx_req (
        .clk         (clk),
        .i_clear     (w_clr),
        .i_load      (w_load),
        .i_msg       (w_load_msg),
        .i_to_parent (w_load_up),
        .i_comm_id   (i_cfg_comm_id),
        .o_acked     (w_acked),
        .tx          (tx)
    );

    assign o_barrier_done = r_done;
    assign o_arrive_cnt   = r_cnt;
    assign o_err_pulse    = r_err;

endmodule

// File: tb/tb_barrier_ctrl.sv
// Directed scenario bench for barrier_ctrl with hand-computed expectations.
module tb_barrier_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        decode_done = 1'b0;
    logic        barrier_pkt = 1'b0;
    logic [15:0] message = '0;
    logic [15:0] comm_id = '0;
    logic        local_arrive = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [15:0] cfg_comm_id = '0;
    logic [7:0]  cfg_node_type = '0;
    logic [7:0]  cfg_num_children = '0;
    logic        barrier_done;
    logic [7:0]  arrive_cnt;
    logic        err_pulse;

    int errors = 0;
    int checks = 0;

    barrier_ctrl_if bif();

    always #5 clk = ~clk;

    barrier_ctrl #(.CNT_WIDTH(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_decode_done      (decode_done),
        .i_barrier_pkt      (barrier_pkt),
        .i_message          (message),
        .i_comm_id          (comm_id),
        .i_local_arrive     (local_arrive),
        .i_cfg_enable       (cfg_enable),
        .i_cfg_comm_id      (cfg_comm_id),
        .i_cfg_node_type    (cfg_node_type),
        .i_cfg_num_children (cfg_num_children),
        .tx                 (bif),
        .o_barrier_done     (barrier_done),
        .o_arrive_cnt       (arrive_cnt),
        .o_err_pulse        (err_pulse)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input logic [15:0] msg, input logic [15:0] cid);
        decode_done = 1'b1;
        barrier_pkt = 1'b1;
        message     = msg;
        comm_id     = cid;
        step();
        decode_done = 1'b0;
        barrier_pkt = 1'b0;
    endtask

    task automatic do_ack();
        bif.tx_ack = 1'b1;
        step();
        bif.tx_ack = 1'b0;
    endtask

    task automatic setup(input logic [7:0] ntype, input logic [7:0] nchild, input logic [15:0] cid);
        cfg_node_type    = ntype;
        cfg_num_children = nchild;
        cfg_comm_id      = cid;
        cfg_enable       = 1'b1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bif.tx_ack = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b want=0", bif.tx_req); end
        checks++; if (bif.tx_msg !== 16'h0) begin errors++; $display("FAIL rst_msg got=%0h want=0", bif.tx_msg); end
        checks++; if (bif.tx_comm_id !== 16'h0) begin errors++; $display("FAIL rst_comm got=%0h want=0", bif.tx_comm_id); end
        checks++; if (bif.tx_to_parent !== 1'b0) begin errors++; $display("FAIL rst_up got=%0b want=0", bif.tx_to_parent); end
        checks++; if (barrier_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b want=0", barrier_done); end
        checks++; if (arrive_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got=%0d want=0", arrive_cnt); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b want=0", err_pulse); end
    endtask

    task automatic test_intermediate();
        setup(8'd1, 8'd2, 16'd5);
        drive_pkt(16'h0001, 16'd5);
        checks++; if (arrive_cnt !== 8'd1) begin errors++; $display("FAIL im_cnt1 got=%0d want=1", arrive_cnt); end
        drive_pkt(16'h0001, 16'd5);
        checks++; if (arrive_cnt !== 8'd2) begin errors++; $display("FAIL im_cnt2 got=%0d want=2", arrive_cnt); end
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL im_noreq got=%0b want=0", bif.tx_req); end
        local_arrive = 1'b1;
        step();
        local_arrive = 1'b0;
        checks++; if (bif.tx_req !== 1'b1) begin errors++; $display("FAIL im_upreq got=%0b want=1", bif.tx_req); end
        checks++; if (bif.tx_msg !== 16'h0001) begin errors++; $display("FAIL im_upmsg got=%0h want=1", bif.tx_msg); end
        checks++; if (bif.tx_to_parent !== 1'b1) begin errors++; $display("FAIL im_upto got=%0b want=1", bif.tx_to_parent); end
        checks++; if (bif.tx_comm_id !== 16'd5) begin errors++; $display("FAIL im_upcomm got=%0d want=5", bif.tx_comm_id); end
        do_ack();
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL im_ackdrop got=%0b want=0", bif.tx_req); end
        drive_pkt(16'h0002, 16'd5);
        checks++; if (bif.tx_req !== 1'b1) begin errors++; $display("FAIL im_dnreq got=%0b want=1", bif.tx_req); end
        checks++; if (bif.tx_msg !== 16'h0002) begin errors++; $display("FAIL im_dnmsg got=%0h want=2", bif.tx_msg); end
        checks++; if (bif.tx_to_parent !== 1'b0) begin errors++; $display("FAIL im_dnto got=%0b want=0", bif.tx_to_parent); end
        checks++; if (barrier_done !== 1'b0) begin errors++; $display("FAIL im_early_done got=%0b want=0", barrier_done); end
        do_ack();
        checks++; if (barrier_done !== 1'b1) begin errors++; $display("FAIL im_done got=%0b want=1", barrier_done); end
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL im_dnack got=%0b want=0", bif.tx_req); end
        checks++; if (arrive_cnt !== 8'd0) begin errors++; $display("FAIL im_cntclr got=%0d want=0", arrive_cnt); end
        step();
        checks++; if (barrier_done !== 1'b0) begin errors++; $display("FAIL im_donepulse got=%0b want=0", barrier_done); end
    endtask

    task automatic test_root();
        setup(8'd0, 8'd1, 16'd9);
        local_arrive = 1'b1;
        drive_pkt(16'h0001, 16'd9);
        local_arrive = 1'b0;
        checks++; if (arrive_cnt !== 8'd1) begin errors++; $display("FAIL rt_cnt got=%0d want=1", arrive_cnt); end
        checks++; if (bif.tx_req !== 1'b1) begin errors++; $display("FAIL rt_req got=%0b want=1", bif.tx_req); end
        checks++; if (bif.tx_msg !== 16'h0002) begin errors++; $display("FAIL rt_msg got=%0h want=2", bif.tx_msg); end
        checks++; if (bif.tx_to_parent !== 1'b0) begin errors++; $display("FAIL rt_to got=%0b want=0", bif.tx_to_parent); end
        do_ack();
        checks++; if (barrier_done !== 1'b1) begin errors++; $display("FAIL rt_done got=%0b want=1", barrier_done); end
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL rt_ackdrop got=%0b want=0", bif.tx_req); end
    endtask

    task automatic test_leaf();
        setup(8'd2, 8'd0, 16'd3);
        local_arrive = 1'b1;
        step();
        local_arrive = 1'b0;
        checks++; if (bif.tx_req !== 1'b1) begin errors++; $display("FAIL lf_req got=%0b want=1", bif.tx_req); end
        checks++; if (bif.tx_msg !== 16'h0001) begin errors++; $display("FAIL lf_msg got=%0h want=1", bif.tx_msg); end
        do_ack();
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL lf_ack got=%0b want=0", bif.tx_req); end
        drive_pkt(16'h0002, 16'd3);
        checks++; if (barrier_done !== 1'b1) begin errors++; $display("FAIL lf_done got=%0b want=1", barrier_done); end
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL lf_noreq got=%0b want=0", bif.tx_req); end
        do_ack();
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL lf_idleack got=%0b want=0", bif.tx_req); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL lf_idleerr got=%0b want=0", err_pulse); end
    endtask

    task automatic test_errors();
        setup(8'd1, 8'd2, 16'd5);
        drive_pkt(16'h0001, 16'd7);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL er_comm got=%0b want=1", err_pulse); end
        checks++; if (arrive_cnt !== 8'd0) begin errors++; $display("FAIL er_commcnt got=%0d want=0", arrive_cnt); end
        drive_pkt(16'h0001, 16'd5);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL er_clean got=%0b want=0", err_pulse); end
        drive_pkt(16'h0001, 16'd5);
        drive_pkt(16'h0001, 16'd5);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL er_extra got=%0b want=1", err_pulse); end
        checks++; if (arrive_cnt !== 8'd2) begin errors++; $display("FAIL er_extracnt got=%0d want=2", arrive_cnt); end
        drive_pkt(16'h0002, 16'd5);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL er_relgather got=%0b want=1", err_pulse); end
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL er_noreq got=%0b want=0", bif.tx_req); end
    endtask

    task automatic test_hold_disable();
        setup(8'd1, 8'd1, 16'd4);
        local_arrive = 1'b1;
        drive_pkt(16'h0001, 16'd4);
        local_arrive = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (bif.tx_req !== 1'b1 || bif.tx_msg !== 16'h0001) begin errors++; $display("FAIL hd_hold%0d got=%0b/%0h want=1/1", i, bif.tx_req, bif.tx_msg); end
            step();
        end
        cfg_enable = 1'b0;
        step();
        checks++; if (bif.tx_req !== 1'b0) begin errors++; $display("FAIL hd_disreq got=%0b want=0", bif.tx_req); end
        checks++; if (arrive_cnt !== 8'd0) begin errors++; $display("FAIL hd_discnt got=%0d want=0", arrive_cnt); end
        cfg_enable = 1'b1;
    endtask

    task automatic test_reset_wait();
        setup(8'd2, 8'd0, 16'd3);
        local_arrive = 1'b1;
        step();
        local_arrive = 1'b0;
        do_ack();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bif.tx_req !== 1'b0 || bif.tx_msg !== 16'h0 || bif.tx_comm_id !== 16'h0 || bif.tx_to_parent !== 1'b0) begin errors++; $display("FAIL rw_tx got=%0b/%0h/%0h/%0b want=0/0/0/0", bif.tx_req, bif.tx_msg, bif.tx_comm_id, bif.tx_to_parent); end
        checks++; if (barrier_done !== 1'b0 || arrive_cnt !== 8'd0 || err_pulse !== 1'b0) begin errors++; $display("FAIL rw_out got=%0b/%0d/%0b want=0/0/0", barrier_done, arrive_cnt, err_pulse); end
        drive_pkt(16'h0002, 16'd3);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL rw_relerr got=%0b want=1", err_pulse); end
        checks++; if (barrier_done !== 1'b0) begin errors++; $display("FAIL rw_nodone got=%0b want=0", barrier_done); end
    endtask

    initial begin
        bif.tx_ack = 1'b0;
        test_reset();
        test_intermediate();
        test_root();
        test_leaf();
        test_errors();
        test_hold_disable();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrier_ctrl.md
Name: barrier_ctrl

Overview:
- Barrier-protocol sequencer for one node of the barrier tree. It sits after the barrier packet decoder and in front of the packet generator / output port lookup.
- Consumes decoded barrier packets (decode_done, barrier_pkt, message, comm_id) and the local host's barrier entry.
- Gathers child arrivals, sends one ARRIVE to the parent (or releases directly when the node is root), waits for RELEASE, then broadcasts RELEASE to the children.
- The packet generator executes each transmit request over a req/ack handshake.

Parameters:
- CNT_WIDTH, 8, width of the child count and arrival counter.
- MSG_ARRIVE, 16'h0001, message code for arrival (up-tree).
- MSG_RELEASE, 16'h0002, message code for release (down-tree).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- decode_done  in  1  one-cycle pulse: decoder result valid
- barrier_pkt  in  1  decoded packet is a barrier packet
- message  in  16  decoded message code
- comm_id  in  16  decoded communicator id
- local_arrive  in  1  one-cycle pulse: local host entered the barrier
- cfg_enable  in  1  block enable
- cfg_comm_id  in  16  communicator served
- cfg_node_type  in  8  0=ROOT, 1=INTERMEDIATE, 2=LEAF
- cfg_num_children  in  CNT_WIDTH  expected child arrivals (0 for LEAF)
- tx_req  out  1  transmit request, held until ack
- tx_msg  out  16  message code to send
- tx_comm_id  out  16  communicator id to send
- tx_to_parent  out  1  1=send to parent, 0=broadcast to children
- tx_ack  in  1  generator accepted request
- barrier_done  out  1  one-cycle pulse: barrier released locally
- arrive_cnt  out  CNT_WIDTH  child arrivals gathered
- err_pulse  out  1  one-cycle pulse: unexpected/dropped barrier packet

Behaviour:
- All outputs are registered. Reset values: tx_req=0, tx_msg=0, tx_comm_id=0, tx_to_parent=0, barrier_done=0, arrive_cnt=0, err_pulse=0, local_seen=0, state=GATHER.
- Relevant event: decode_done && barrier_pkt && comm_id==cfg_comm_id. Non-barrier packets are ignored silently. A barrier packet with a mismatched comm_id is dropped and raises err_pulse.
- States:
  - GATHER:
    - A relevant ARRIVE increments arrive_cnt. If arrive_cnt is already equal to cfg_num_children, the ARRIVE is dropped and err_pulse is raised; the counter never exceeds cfg_num_children.
    - local_arrive sets local_seen. A second local_arrive while local_seen is set raises err_pulse.
    - RELEASE in this state: dropped, err_pulse.
    - Completion condition uses next-state values: (arrive_cnt_next==cfg_num_children) && local_seen_next.
    - On completion: ROOT goes to SEND_DOWN; otherwise goes to SEND_UP.
  - SEND_UP:
    - tx_req=1, tx_msg=MSG_ARRIVE, tx_to_parent=1, tx_comm_id=cfg_comm_id.
    - On tx_ack: tx_req drops the next cycle and the state goes to WAIT_RELEASE.
  - WAIT_RELEASE:
    - RELEASE goes to SEND_DOWN if cfg_num_children!=0. Otherwise barrier_done pulses and the state goes to GATHER.
    - ARRIVE in this state: dropped, err_pulse.
  - SEND_DOWN:
    - A node with cfg_num_children==0 (LEAF, or a ROOT with no children) skips the broadcast: barrier_done pulses and the state goes to GATHER.
    - Otherwise: tx_req=1, tx_msg=MSG_RELEASE, tx_to_parent=0. On tx_ack: barrier_done pulses, arrive_cnt and local_seen clear, and the state goes to GATHER.
  - barrier_done always clears arrive_cnt and local_seen.
- Latency:
  - Completing event at cycle N gives tx_req=1 at N+1.
  - tx_ack at cycle M gives tx_req=0 at M+1; barrier_done pulses at M+1.
  - tx_ack is ignored while tx_req=0.
- Simultaneous events: decode_done ARRIVE and local_arrive in the same cycle are both counted. Events in SEND_UP and SEND_DOWN other than RELEASE/ARRIVE errors are dropped with err_pulse.
- cfg_enable=0: synchronous clear identical to reset, except that the cfg inputs are untouched. This also applies mid-handshake: tx_req drops the next cycle.
- cfg_* inputs may change only when state==GATHER and arrive_cnt==0; otherwise the behaviour is undefined.

Decomposition:
- Shared package barrier_pkg holds:
  - message codes MSG_ARRIVE and MSG_RELEASE;
  - node type codes NODE_ROOT, NODE_INTERMEDIATE, NODE_LEAF;
  - state encodings GATHER, SEND_UP, WAIT_RELEASE, SEND_DOWN.
- One sub-module, barrier_tx_req, holds the req/ack register pair (tx_req, tx_msg, tx_to_parent, tx_comm_id), loaded by the FSM and cleared on ack.

Test Plan:
- INTERMEDIATE, 2 children, comm 5: ARRIVE(5), ARRIVE(5), local_arrive. Expect tx_req with tx_msg=1, tx_to_parent=1, tx_comm_id=5 one cycle after the last event; ack, then RELEASE(5). Expect tx_msg=2, tx_to_parent=0; ack, then barrier_done pulse and arrive_cnt=0.
- ROOT, 1 child: local_arrive and ARRIVE in the same cycle. Expect arrive_cnt=1 and a direct SEND_DOWN with tx_msg=2, no up request; barrier_done one cycle after ack.
- LEAF, 0 children: local_arrive gives an up request; ack, then RELEASE gives barrier_done with no tx_req.
- Errors: ARRIVE with comm 7 gives err_pulse and arrive_cnt unchanged. A third ARRIVE with 2 children gives err_pulse and arrive_cnt stays 2. RELEASE in GATHER gives err_pulse.
- Hold: with tx_req=1 and tx_ack low for 10 cycles, tx_req and tx_msg stay stable. Deassert cfg_enable mid-request: tx_req=0 and arrive_cnt=0 next cycle.
- Reset during WAIT_RELEASE: next cycle all outputs are at reset values and a subsequent RELEASE raises err_pulse.
